// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared encodings and helpers for the arbitrated bus mux
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Bits needed to index n items; never less than one so selects stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - winner selection, fixed highest-index or round-robin from ptr
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = ARB_FIXED,
  localparam int SELW   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SELW-1:0]   idx
);

  int   cand;
  logic found;

  // Pick exactly one requester; grant and idx are unconditioned by load.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    if (RR_MODE == ARB_RR) begin
      // Walk upward from ptr with wrap; ptr < 2**SELW < 2*NUM_CH so one fold suffices.
      for (int k = 0; k < NUM_CH; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_CH) cand = cand - NUM_CH;
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          idx         = SELW'(cand);
        end
      end
    end else begin
      // Ascending scan, later hits override, so the highest index wins.
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          idx      = SELW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/arb_bus_mux.sv
// rtl/arb_bus_mux.sv - arbitrated N-channel mux into a single-entry output register
module arb_bus_mux
  import arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DW      = 8,
  parameter int RR_MODE = ARB_FIXED,
  localparam int SELW   = clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*DW-1:0] data_in,
  output logic [NUM_CH-1:0]    gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_sel
);

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q;
  logic [SELW-1:0]   win_idx;
  logic [NUM_CH-1:0] win_grant;
  logic [DW-1:0]     win_data;
  logic              load;

  assign out_valid = (state_q == ST_FULL);

  // The register accepts a word when empty or being drained this cycle; rst_n
  // gating keeps gnt quiet while reset is held.
  assign load = rst_n & (|req) & (~out_valid | out_ready);
  assign gnt  = load ? win_grant : '0;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // One-hot AND-OR mux of the winning channel's data.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_grant[i]) win_data = data_in[i*DW +: DW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: a load always leaves us FULL, a drain without load empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL: begin
        if (load)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output word, source index and round-robin pointer update only on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else if (load) begin
      out_data <= win_data;
      out_sel  <= win_idx;
      if (RR_MODE == ARB_RR) begin
        if (int'(win_idx) == NUM_CH - 1) ptr_q <= '0;
        else                             ptr_q <= win_idx + SELW'(1);
      end
    end
  end

endmodule
